fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions in a small in-order FIFO.
- Presents instr/pc/pc_plus4 to decode, where instr[6:0] feeds the decoder op input.
- Accepts redirects (taken branch, jal) from execute and discards stale in-flight fetches.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: widths, reset PC, NOP and
// major opcodes used by fetch and the main decoder.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count, flush and
// simultaneous push/pop; head is read combinationally.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  import riscv_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // a full FIFO may still accept a push if the head leaves
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  // pointer and count next state; flush wins
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = bump(wr_q);
      if (do_pop)  rd_d = bump(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request channel, in-order
// instruction buffer. Option: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC =
    XLEN'(riscv_pkg::RESET_PC_DEFAULT),
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);
  import riscv_pkg::*;

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = FCW + OW + 1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic              started_q;
  logic [OW-1:0]     out_cnt;
  logic [FCW-1:0]    icnt;
  logic [2*XLEN-1:0] ihead;
  logic [XLEN-1:0]   tag;
  logic [XLEN-1:0]   tgt;
  logic              halted;
  logic [SW-1:0]     occ;
  logic              req_fire;
  logic              rsp_acc;
  logic              push;
  logic              pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_q;
  logic mis_q;
  logic mis_req;

  assign mis_req = redirect_valid &&
                   (redirect_target[1:0] != 2'b00);
  assign tgt     = redirect_target;
  assign halted  = halted_q;
  assign fetch_misaligned = mis_q;

  // misaligned redirect halts fetch until an aligned one
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (redirect_valid) halted_q <= mis_req;
      mis_q <= mis_req;
    end
  end
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  assign tgt    = redirect_target & ALIGN_MASK;
  assign halted = 1'b0;
`endif

  // live requests: buffered plus in flight, minus doomed
  assign occ = SW'(icnt) + SW'(out_cnt) - SW'(drop_q);

  assign imem_req_valid =
    started_q && !redirect_valid && !halted &&
    (out_cnt < OW'(MAX_OUTSTANDING)) &&
    (occ < SW'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_acc  = imem_rsp_valid && started_q &&
                    (out_cnt != '0);
  assign push     = rsp_acc && (drop_q == '0) &&
                    !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  // PC and drop counter next state; redirect wins
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = tgt;
      drop_d = out_cnt - OW'(rsp_acc);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_acc && (drop_q != '0))
        drop_d = drop_q - OW'(1);
    end
  end

  // PC, drop counter and post-reset quiet cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_ififo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({imem_rsp_data, tag}),
    .pop_i       (pop),
    .head_o      (ihead),
    .count_o     (icnt)
  );

  // tag queue occupancy doubles as the outstanding count
  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tagq (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (rsp_acc),
    .head_o      (tag),
    .count_o     (out_cnt)
  );

  assign instr_valid    = (icnt != '0);
  assign instr          = instr_valid ?
                          ihead[2*XLEN-1:XLEN] : '0;
  assign instr_pc       = instr_valid ?
                          ihead[XLEN-1:0] : '0;
  assign instr_pc_plus4 = instr_valid ?
                          ihead[XLEN-1:0] + XLEN'(4) : '0;

`ifndef SYNTHESIS
  // a response with nothing outstanding is a protocol error
  always_ff @(posedge clk) begin
    if (!reset && started_q && imem_rsp_valid)
      assert (out_cnt != '0)
      else $error("fetch_unit: response with none pending");
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a stream model.
// Optional build: FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int MAXO  = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
  bit          mis_exp;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    bit          arr;
  } live_t;

  req_t        pend[$];
  live_t       live[$];
  int          cyc;
  int          ep;
  int          since_rst;
  int          delivered;
  bit          halted;
  logic [31:0] req_pc;
  int          errs;
  int          checks;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ NOP;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    pend.delete();
    live.delete();
    ep++;
    req_pc    = 32'h0;
    halted    = 1'b0;
    since_rst = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_exp   = 1'b0;
`endif
  endtask

  task automatic step(input bit rdir,
                      input logic [31:0] tgt,
                      input int rq_pct,
                      input int ir_pct,
                      input int maxlat);
    bit   rq, ir, have, fire, exp_req, exp_iv, done;
    req_t r;
    int   due;
    @(negedge clk);
    reset = 1'b0;
    rq = ($urandom_range(0, 99) < rq_pct);
    ir = ($urandom_range(0, 99) < ir_pct);
    redirect_valid  = rdir;
    redirect_target = tgt;
    imem_req_ready  = rq;
    instr_ready     = ir;
    have = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = have;
    imem_rsp_data  = have ? mem_word(pend[0].addr)
                          : $urandom;
    #1;
    if (since_rst == 0) begin
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_pc4", instr_pc_plus4, 0);
    end
    exp_req = (since_rst > 0) && !rdir && !halted &&
              (pend.size() < MAXO) &&
              (live.size() < DEPTH);
    exp_iv = (live.size() > 0) && live[0].arr;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (imem_req_valid && exp_req)
      chk("req_addr", imem_addr, req_pc);
    if (instr_valid && exp_iv) begin
      chk("instr_pc", instr_pc, live[0].pc);
      chk("instr", instr, mem_word(live[0].pc));
      chk("pc_plus4", instr_pc_plus4, live[0].pc + 4);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misaligned", 32'(fetch_misaligned),
        32'(mis_exp));
`endif
    fire = imem_req_valid && rq;
    if (have) begin
      r = pend.pop_front();
      if (!rdir && r.ep == ep) begin
        done = 1'b0;
        for (int i = 0; i < live.size(); i++)
          if (!done && !live[i].arr) begin
            live[i].arr = 1'b1;
            done = 1'b1;
          end
      end
    end
    if (instr_valid && ir && exp_iv) begin
      void'(live.pop_front());
      delivered++;
    end
    if (fire) begin
      due = cyc + $urandom_range(1, maxlat);
      if (pend.size() > 0 && due <= pend[$].due)
        due = pend[$].due + 1;
      pend.push_back('{imem_addr, due, ep});
      live.push_back('{imem_addr, 1'b0});
      req_pc = req_pc + 4;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_exp = 1'b0;
`endif
    if (rdir) begin
      ep++;
      live.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_exp = (tgt[1:0] != 2'b00);
      halted  = mis_exp;
      req_pc  = tgt;
`else
      req_pc  = tgt & ~32'h3;
`endif
    end
    cyc++;
    since_rst++;
  endtask

  initial begin
    logic [31:0] t;
    bit          rd;
    errs = 0;
    checks = 0;
    cyc = 0;
    ep = 0;
    delivered = 0;
    do_reset();
    // streaming from reset, fixed 1-cycle memory
    repeat (14) step(1'b0, 0, 100, 100, 1);
    // decode stall then release
    repeat (5) step(1'b0, 0, 100, 0, 1);
    repeat (8) step(1'b0, 0, 100, 100, 1);
    // redirect while requests are in flight
    do_reset();
    repeat (4) step(1'b0, 0, 100, 100, 3);
    step(1'b1, 32'h100, 100, 100, 3);
    repeat (12) step(1'b0, 0, 100, 100, 3);
    // PC wraps past the top of the address space
    step(1'b1, 32'hFFFF_FFF8, 100, 100, 2);
    repeat (12) step(1'b0, 0, 100, 100, 2);
`ifdef FETCH_MISALIGN_CHECK_EN
    step(1'b1, 32'h102, 100, 100, 1);
    repeat (6) step(1'b0, 0, 100, 100, 1);
    step(1'b1, 32'h200, 100, 100, 1);
    repeat (8) step(1'b0, 0, 100, 100, 1);
`endif
    // random traffic, redirects and a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rd = ($urandom_range(0, 99) < 4);
      t  = $urandom & 32'h0000_0FFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(0, 4) == 0)
        t = t | 32'($urandom_range(1, 3));
`else
      t = t | 32'($urandom_range(0, 3));
`endif
      step(rd, t, 60, 65, 3);
    end
    chk("deliveries", 32'(delivered > 200), 1);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
